muldiv_ctrl: RTL and testbench

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/cpu_pkg.sv | 45 ++++
 rtl/div_iter.sv | 59 +++++
 rtl/muldiv_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: HI/LO-class operation codes plus the multiply/divide
// unit's state encoding, result kinds and iteration count.
package cpu_pkg;

    localparam int DIV_CYCLES = 32;

    typedef enum logic [3:0] {
        OP_MULT  = 4'd0,
        OP_MULTU = 4'd1,
        OP_DIV   = 4'd2,
        OP_DIVU  = 4'd3,
        OP_MUL   = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MADD  = 4'd7,
        OP_MADDU = 4'd8,
        OP_MSUB  = 4'd9,
        OP_MSUBU = 4'd10
    } operation_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_ACC,
        ST_DIV,
        ST_DONE
    } muldiv_state_t;

    // What the completing cycle does with HI/LO and resp_data.
    typedef enum logic [2:0] {
        RES_PROD,
        RES_GPR,
        RES_ACC,
        RES_DIV,
        RES_DIVZ,
        RES_HI,
        RES_LO,
        RES_ILL
    } res_kind_t;

    function automatic logic op_is_signed(input operation_t op);
        return op inside {OP_MULT, OP_DIV, OP_MUL, OP_MADD, OP_MSUB};
    endfunction

endpackage

// File: rtl/div_iter.sv
// Radix-2 restoring unsigned divider: start performs the first of DIV_CYCLES
// iterations, done pulses for one cycle once quotient/remainder are final.
module div_iter
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [5:0]  cnt;
    logic [31:0] dvs;
    logic [31:0] step_dvs;
    logic [63:0] step_src;
    logic [63:0] step_res;
    logic [32:0] shifted;

    assign step_dvs = start ? divisor : dvs;
    assign step_src = start ? {32'd0, dividend} : {remainder, quotient};

    always_comb begin
        shifted  = {step_src[63:32], step_src[31]};
        step_res = {shifted[31:0], step_src[30:0], 1'b0};
        if (shifted >= {1'b0, step_dvs}) begin
            step_res = {shifted[31:0] - step_dvs, step_src[30:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt       <= '0;
            done      <= 1'b0;
            dvs       <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (abort) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (start) begin
            dvs                   <= divisor;
            {remainder, quotient} <= step_res;
            cnt                   <= 6'(DIV_CYCLES - 1);
            done                  <= 1'b0;
        end else if (cnt != 6'd0) begin
            {remainder, quotient} <= step_res;
            cnt                   <= cnt - 6'd1;
            done                  <= (cnt == 6'd1);
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide controller. Define MULDIV_ACC_EN to execute
// MADD/MADDU/MSUB/MSUBU; otherwise they complete as illegal operations.
module muldiv_ctrl
    import cpu_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  operation_t  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        flush,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_illegal,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy
);

    muldiv_state_t state;
    muldiv_state_t first_d;
    res_kind_t     kind_q;
    res_kind_t     kind_d;
    logic [1:0]    mul_cnt;
    logic          accept;
    logic          req_sgn;
    logic [31:0]   a_r;
    logic [31:0]   b_r;
    logic          sgn_r;
    logic          neg_q;
    logic          neg_r;
    logic [31:0]   dvd_abs;
    logic [31:0]   dvs_abs;
    logic          div_start;
    logic          div_done;
    logic [31:0]   div_quo;
    logic [31:0]   div_rem;
    logic signed [32:0] mul_a;
    logic signed [32:0] mul_b;
    logic [63:0]   mul_comb;
    logic [63:0]   mul_final;
`ifdef MULDIV_ACC_EN
    logic          sub_r;
    logic [63:0]   acc_q;
`endif

    assign accept  = req_valid && req_ready && !flush;
    assign req_sgn = op_is_signed(req_op);
    assign dvd_abs = (req_sgn && req_a[31]) ? -req_a : req_a;
    assign dvs_abs = (req_sgn && req_b[31]) ? -req_b : req_b;

    // NOTE: every always_comb output is given a default first so no latch is inferred.
    always_comb begin
        kind_d = RES_ILL;
        case (req_op)
            OP_MULT, OP_MULTU: kind_d = RES_PROD;
            OP_MUL:            kind_d = RES_GPR;
            OP_DIV, OP_DIVU:   kind_d = (req_b == '0) ? RES_DIVZ : RES_DIV;
            OP_MTHI:           kind_d = RES_HI;
            OP_MTLO:           kind_d = RES_LO;
`ifdef MULDIV_ACC_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: kind_d = RES_ACC;
`endif
            default:           kind_d = RES_ILL;
        endcase

        first_d = ST_DONE;
        case (kind_d)
            RES_PROD, RES_GPR: first_d = (MUL_LAT == 1) ? ST_DONE : ST_MUL;
`ifdef MULDIV_ACC_EN
            RES_ACC:           first_d = (MUL_LAT == 1) ? ST_ACC : ST_MUL;
`endif
            RES_DIV:           first_d = ST_DIV;
            default:           first_d = ST_DONE;
        endcase
    end

    assign div_start = accept && (kind_d == RES_DIV);

    div_iter u_div (
        .clk       (clk),
        .resetn    (resetn),
        .start     (div_start),
        .abort     (flush),
        .dividend  (dvd_abs),
        .divisor   (dvs_abs),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // Operands are held for the whole operation, so the pipeline simply refills.
    assign mul_a    = {sgn_r & a_r[31], a_r};
    assign mul_b    = {sgn_r & b_r[31], b_r};
    assign mul_comb = 64'(mul_a) * 64'(mul_b);

    generate
        if (MUL_LAT > 1) begin : g_pipe
            logic [63:0] pipe [MUL_LAT-1];
            always_ff @(posedge clk) begin
                pipe[0] <= mul_comb;
                for (int i = 1; i < MUL_LAT - 1; i++) pipe[i] <= pipe[i-1];
            end
            assign mul_final = pipe[MUL_LAT-2];
        end else begin : g_comb
            assign mul_final = mul_comb;
        end
    endgenerate

    // NOTE: operand and accumulator registers carry no reset; they are always loaded before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_r   <= req_a;
            b_r   <= req_b;
            sgn_r <= req_sgn;
            neg_q <= req_sgn && (req_a[31] ^ req_b[31]);
            neg_r <= req_sgn && req_a[31];
`ifdef MULDIV_ACC_EN
            sub_r <= req_op inside {OP_MSUB, OP_MSUBU};
`endif
        end
`ifdef MULDIV_ACC_EN
        if (state == ST_ACC) acc_q <= sub_r ? {hi, lo} - mul_final : {hi, lo} + mul_final;
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= ST_IDLE;
            kind_q       <= RES_ILL;
            mul_cnt      <= '0;
            hi           <= '0;
            lo           <= '0;
            resp_valid   <= 1'b0;
            resp_data    <= '0;
            resp_illegal <= 1'b0;
            busy         <= 1'b0;
            req_ready    <= 1'b1;
        end else begin
            resp_valid   <= 1'b0;
            resp_data    <= '0;
            resp_illegal <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state     <= first_d;
                        kind_q    <= kind_d;
                        mul_cnt   <= 2'(MUL_LAT - 2);
                        busy      <= 1'b1;
                        req_ready <= 1'b0;
                    end
                end
                ST_MUL: begin
                    if (flush) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                    end else if (mul_cnt == 2'd0) begin
`ifdef MULDIV_ACC_EN
                        state <= (kind_q == RES_ACC) ? ST_ACC : ST_DONE;
`else
                        state <= ST_DONE;
`endif
                    end else begin
                        mul_cnt <= mul_cnt - 2'd1;
                    end
                end
`ifdef MULDIV_ACC_EN
                ST_ACC: begin
                    if (flush) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                    end else begin
                        state <= ST_DONE;
                    end
                end
`endif
                ST_DIV: begin
                    if (flush) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                    end else if (div_done) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // A flush arriving now is too late: the result still retires.
                    resp_valid   <= 1'b1;
                    resp_illegal <= (kind_q == RES_ILL);
                    if (kind_q == RES_GPR) resp_data <= mul_final[31:0];
                    case (kind_q)
                        RES_PROD: {hi, lo} <= mul_final;
                        RES_DIV: begin
                            lo <= neg_q ? -div_quo : div_quo;
                            hi <= neg_r ? -div_rem : div_rem;
                        end
                        RES_DIVZ: begin
                            hi <= a_r;
                            lo <= '1;
                        end
                        RES_HI: hi <= a_r;
                        RES_LO: lo <= a_r;
`ifdef MULDIV_ACC_EN
                        RES_ACC: {hi, lo} <= acc_q;
`endif
                        default: ;
                    endcase
                    state     <= ST_IDLE;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= ST_IDLE;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with MUL_LAT=2; MADD expectations follow MULDIV_ACC_EN.
module tb_muldiv_ctrl;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        req_valid = 1'b0;
    logic        flush = 1'b0;
    operation_t  req_op = OP_MULT;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        req_ready;
    logic        resp_valid;
    logic        resp_illegal;
    logic        busy;
    logic [31:0] resp_data;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    int lat;
    int busy_n;
    int seen;

    muldiv_ctrl #(.MUL_LAT(2)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_a        (req_a),
        .req_b        (req_b),
        .flush        (flush),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .resp_illegal (resp_illegal),
        .hi           (hi),
        .lo           (lo),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called #1 after an edge; returns the edge count from acceptance to resp_valid.
    task automatic run_op(input operation_t op, input logic [31:0] a, input logic [31:0] b,
                          output int l, output int bn);
        check("req_ready_before_issue", req_ready, 1);
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        l  = -1;
        bn = 0;
        for (int n = 1; n <= 64; n++) begin
            @(posedge clk);
            #1;
            if (resp_valid) begin
                l = n;
                break;
            end
            if (busy) bn++;
        end
    endtask

    initial begin
        #1 resetn = 1'b0;
        #1;
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_resp_illegal", resp_illegal, 0);
        check("rst_busy", busy, 0);
        check("rst_req_ready", req_ready, 1);
        #20;
        @(negedge clk) resetn = 1'b1;
        @(posedge clk);
        #1;

        run_op(OP_MULT, 32'hFFFF_FFFF, 32'd2, lat, busy_n);
        check("mult_lat", lat, 2);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFE);
        check("mult_resp_data", resp_data, 0);
        check("mult_illegal", resp_illegal, 0);
        @(posedge clk);
        #1 check("resp_single_pulse", resp_valid, 0);

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, lat, busy_n);
        check("multu_lat", lat, 2);
        check("multu_hi", hi, 32'h0000_0001);
        check("multu_lo", lo, 32'hFFFF_FFFE);

        run_op(OP_MUL, 32'hFFFF_FFFD, 32'd5, lat, busy_n);
        check("mul_lat", lat, 2);
        check("mul_resp_data", resp_data, 32'hFFFF_FFF1);
        check("mul_hi_kept", hi, 32'h0000_0001);
        check("mul_lo_kept", lo, 32'hFFFF_FFFE);

        run_op(OP_MTHI, 32'h1111_1111, 32'd0, lat, busy_n);
        check("mthi_lat", lat, 1);
        check("mthi_hi", hi, 32'h1111_1111);
        run_op(OP_MTLO, 32'h2222_2222, 32'd0, lat, busy_n);
        check("mtlo_lat", lat, 1);
        check("mtlo_lo", lo, 32'h2222_2222);
        check("mtlo_hi_kept", hi, 32'h1111_1111);

        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, busy_n);
        check("div_lat", lat, 33);
        check("div_busy_cycles", busy_n, 32);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, busy_n);
        check("div_ovf_lat", lat, 33);
        check("div_ovf_lo", lo, 32'h8000_0000);
        check("div_ovf_hi", hi, 32'h0000_0000);

        run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, lat, busy_n);
        check("div_negdvs_lo", lo, 32'hFFFF_FFFD);
        check("div_negdvs_hi", hi, 32'd1);

        run_op(OP_DIVU, 32'd100, 32'd7, lat, busy_n);
        check("divu_lat", lat, 33);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);

        run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd10, lat, busy_n);
        check("divu_big_lo", lo, 32'h1999_9999);
        check("divu_big_hi", hi, 32'd5);

        run_op(OP_DIVU, 32'd7, 32'd0, lat, busy_n);
        check("divu_zero_lat", lat, 1);
        check("divu_zero_hi", hi, 32'd7);
        check("divu_zero_lo", lo, 32'hFFFF_FFFF);

        run_op(OP_DIV, 32'hFFFF_FFFB, 32'd0, lat, busy_n);
        check("div_zero_lat", lat, 1);
        check("div_zero_hi", hi, 32'hFFFF_FFFB);
        check("div_zero_lo", lo, 32'hFFFF_FFFF);

        // Flush a DIV at cycle 10.
        req_op = OP_DIV; req_a = 32'd100; req_b = 32'd3; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("flush_busy_before", busy, 1);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush_req_ready", req_ready, 1);
        check("flush_busy_after", busy, 0);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1 if (resp_valid) seen++;
        end
        check("flush_no_resp", seen, 0);
        check("flush_hi_kept", hi, 32'hFFFF_FFFB);
        check("flush_lo_kept", lo, 32'hFFFF_FFFF);

        // Flush together with a request in IDLE: not accepted.
        req_op = OP_MTLO; req_a = 32'h0000_DEAD; req_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 begin req_valid = 1'b0; flush = 1'b0; end
        check("flush_idle_busy", busy, 0);
        seen = 0;
        repeat (3) begin
            @(posedge clk);
            #1 if (resp_valid) seen++;
        end
        check("flush_idle_no_resp", seen, 0);
        check("flush_idle_lo_kept", lo, 32'hFFFF_FFFF);

        // Flush during the completing cycle: the result still retires.
        req_op = OP_MTHI; req_a = 32'h0000_0055; req_valid = 1'b1;
        @(posedge clk);
        #1 begin req_valid = 1'b0; flush = 1'b1; end
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush_done_resp", resp_valid, 1);
        check("flush_done_hi", hi, 32'h0000_0055);

        run_op(operation_t'(4'hD), 32'h99, 32'h99, lat, busy_n);
        check("illegal_lat", lat, 1);
        check("illegal_flag", resp_illegal, 1);
        check("illegal_resp_data", resp_data, 0);
        check("illegal_hi_kept", hi, 32'h0000_0055);
        check("illegal_lo_kept", lo, 32'hFFFF_FFFF);

        run_op(OP_MTHI, 32'd0, 32'd0, lat, busy_n);
        run_op(OP_MTLO, 32'hFFFF_FFFF, 32'd0, lat, busy_n);
        run_op(OP_MADD, 32'd1, 32'd1, lat, busy_n);
`ifdef MULDIV_ACC_EN
        check("madd_lat", lat, 3);
        check("madd_illegal", resp_illegal, 0);
        check("madd_hi", hi, 32'd1);
        check("madd_lo", lo, 32'd0);
        run_op(OP_MSUB, 32'd2, 32'd3, lat, busy_n);
        check("msub_lat", lat, 3);
        check("msub_hi", hi, 32'd0);
        check("msub_lo", lo, 32'hFFFF_FFFA);
`else
        check("madd_off_lat", lat, 1);
        check("madd_off_illegal", resp_illegal, 1);
        check("madd_off_hi", hi, 32'd0);
        check("madd_off_lo", lo, 32'hFFFF_FFFF);
`endif

        // Reset asserted at cycle 5 of a DIV.
        req_op = OP_DIV; req_a = 32'd1000; req_b = 32'd7; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 resetn = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_req_ready", req_ready, 1);
        check("midrst_resp_valid", resp_valid, 0);
        check("midrst_hi", hi, 0);
        check("midrst_lo", lo, 0);
        @(negedge clk) resetn = 1'b1;
        @(posedge clk);
        #1;
        run_op(OP_MTLO, 32'h0000_1234, 32'd0, lat, busy_n);
        check("post_rst_mtlo_lat", lat, 1);
        check("post_rst_mtlo_lo", lo, 32'h0000_1234);
        check("post_rst_hi", hi, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
